// File: rtl/uart_apb_pkg.sv
// Shared types for the two-requester APB arbiter in front of the UART.
// FSM states, bus widths and the requester id.
package uart_apb_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/uart_apb_arb_if.sv
// Requester and APB signal bundle for uart_apb_arb.
// master: the arbiter's view; slave: the environment's view.
interface uart_apb_arb_if;
  import uart_apb_pkg::*;

  logic          m0_req;
  logic          m0_write;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_done;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_write;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_done;
  logic [DW-1:0] m1_rdata;

  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;

  modport master (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    input  pready, prdata,
    output m0_done, m0_rdata,
    output m1_done, m1_rdata,
    output psel, penable, pwrite,
    output paddr, pwdata
  );

  modport slave (
    output m0_req, m0_write, m0_addr, m0_wdata,
    output m1_req, m1_write, m1_addr, m1_wdata,
    output pready, prdata,
    input  m0_done, m0_rdata,
    input  m1_done, m1_rdata,
    input  psel, penable, pwrite,
    input  paddr, pwdata
  );

endinterface

// File: rtl/uart_apb_arb_sel.sv
// Winner selection between the two eligible requesters.
// UART_APB_ARB_RR_EN: round-robin on contention, else requester 0 wins.
module uart_apb_arb_sel
  import uart_apb_pkg::*;
(
  input  logic    elig0,
  input  logic    elig1,
  input  req_id_t last,
  output logic    gnt_vld,
  output req_id_t gnt_id
);

  req_id_t pref;

`ifdef UART_APB_ARB_RR_EN
  assign pref = ~last;
`else
  logic unused_last;
  assign unused_last = last;
  assign pref = 1'b0;
`endif

  always_comb begin
    gnt_vld = elig0 | elig1;
    gnt_id  = 1'b0;
    unique case (1'b1)
      (elig0 & elig1):  gnt_id = pref;
      (elig1 & ~elig0): gnt_id = 1'b1;
      (elig0 & ~elig1): gnt_id = 1'b0;
      default:          gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_apb_arb.sv
// Two-requester arbiter driving one APB transfer at a time to the UART.
// UART_APB_ARB_RR_EN selects round-robin arbitration on contention.
module uart_apb_arb
  import uart_apb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_,
  uart_apb_arb_if.master bus
);

  state_e        state_q, state_d;
  req_id_t       id_q, id_d;
  req_id_t       lg_q, lg_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;

  logic          elig0, elig1;
  logic          gnt_vld;
  req_id_t       gnt_id;
  logic          busy;

  // a requester finishing this cycle may not be re-granted yet
  assign elig0 = bus.m0_req & ~done0_q;
  assign elig1 = bus.m1_req & ~done1_q;

  uart_apb_arb_sel u_sel (
    .elig0   (elig0),
    .elig1   (elig1),
    .last    (lg_q),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    lg_d    = lg_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          id_d    = gnt_id;
          wr_d    = gnt_id ? bus.m1_write : bus.m0_write;
          addr_d  = gnt_id ? bus.m1_addr  : bus.m0_addr;
          wdata_d = gnt_id ? bus.m1_wdata : bus.m0_wdata;
          state_d = SETUP;
`ifdef UART_APB_ARB_RR_EN
          lg_d    = gnt_id;
`endif
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          state_d = IDLE;
          done0_d = ~id_q;
          done1_d = id_q;
          if (!wr_q) rdata_d = bus.prdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      lg_q    <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      lg_q    <= lg_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign bus.psel    = busy;
  assign bus.penable = (state_q == ACCESS);
  assign bus.pwrite  = busy & wr_q;
  assign bus.paddr   = busy ? addr_q  : '0;
  assign bus.pwdata  = busy ? wdata_q : '0;

  assign bus.m0_done  = done0_q;
  assign bus.m1_done  = done1_q;
  assign bus.m0_rdata = rdata_q;
  assign bus.m1_rdata = rdata_q;

endmodule

// File: tb/tb_uart_apb_arb.sv
// Randomized scoreboard bench for uart_apb_arb.
// Define UART_APB_ARB_RR_EN for both bench and RTL to check round-robin.
module tb_uart_apb_arb;

  logic clk = 1'b0;
  logic rst_;

  uart_apb_arb_if bus();

  uart_apb_arb dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit          id;
    bit          w;
    logic [31:0] rd;
    int          dc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          pend[2];
  bit          granted[2];
  int          pend_cyc[2];
  bit          tx_w[2];
  logic [31:0] tx_a[2];
  logic [31:0] tx_d[2];
  bit          last = 1'b1;
  bit          force_wait = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      bus.m0_req = r; bus.m0_write = w;
      bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = r; bus.m1_write = w;
      bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  function automatic bit done_of(input int i);
    return (i == 0) ? bus.m0_done : bus.m1_done;
  endfunction

  task automatic issue(input int i, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    tx_w[i] = w; tx_a[i] = a; tx_d[i] = d;
    set_req(i, 1'b1, w, a, d);
    pend_cyc[i] = cyc;
    pend[i] = 1'b1;
  endtask

  // requester: issue, optionally disturb inputs once granted, await done
  task automatic drv(input int i, input int ntx);
    int gap;
    int wd;
    gap = $urandom_range(0, 3);
    for (int t = 0; t < ntx; t++) begin
      repeat (gap) begin @(posedge clk); #1; end
      issue(i, bit'($urandom_range(0, 1)), $urandom, $urandom);
      wd = 0;
      do begin
        @(posedge clk); #1;
        wd++;
        if (!done_of(i) && granted[i] && $urandom_range(0, 3) == 0)
          set_req(i, bit'($urandom_range(0, 7) != 0),
                  bit'($urandom_range(0, 1)), $urandom, $urandom);
      end while (!done_of(i) && wd < 300);
      if (wd >= 300) begin
        checks++; errors++;
        $display("FAIL drv%0d_timeout: got no done, required done", i);
      end
      granted[i] = 1'b0;
      gap = $urandom_range(0, 3);
      if (gap == 0) begin
        set_req(i, 1'b1, tx_w[i], tx_a[i], tx_d[i]);
        gap = 1;
      end else begin
        set_req(i, 1'b0, 1'b0, '0, '0);
      end
    end
    set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  // reference model + APB slave, sampled mid-cycle
  initial begin
    bit          c0, c1;
    int          w, nw, k;
    logic [31:0] ex_a, ex_d, rdv;
    bit          ex_w;
    nw = 0; k = 0; ex_a = '0; ex_d = '0; ex_w = 1'b0; rdv = '0;
    bus.pready = 1'b0;
    bus.prdata = '0;
    forever begin
      @(posedge clk); #2;
      if (rst_ !== 1'b1) begin
        bus.pready = 1'b0;
        continue;
      end
      if (bus.psel && !bus.penable) begin
        c0 = pend[0] && (pend_cyc[0] < cyc);
        c1 = pend[1] && (pend_cyc[1] < cyc);
        if (!c0 && !c1) begin
          checks++; errors++;
          $display("FAIL setup_grant: got SETUP, required no grant");
          ex_a = bus.paddr; ex_d = bus.pwdata; ex_w = bus.pwrite;
          nw = 0;
        end else begin
`ifdef UART_APB_ARB_RR_EN
          w = (c0 && c1) ? (last ? 0 : 1) : (c1 ? 1 : 0);
`else
          w = c0 ? 0 : 1;
`endif
          chk("setup_paddr", bus.paddr, tx_a[w]);
          chk("setup_pwdata", bus.pwdata, tx_d[w]);
          chk("setup_pwrite", 32'(bus.pwrite), 32'(tx_w[w]));
          pend[w] = 1'b0;
          granted[w] = 1'b1;
          last = bit'(w);
          ex_a = tx_a[w]; ex_d = tx_d[w]; ex_w = tx_w[w];
          if (force_wait)
            nw = 60;
          else if ($urandom_range(0, 3) == 0)
            nw = $urandom_range(3, 8);
          else
            nw = $urandom_range(0, 2);
          rdv = $urandom;
          sb.push_back('{id: (w == 1), w: tx_w[w], rd: rdv,
                         dc: cyc + 2 + nw});
        end
        k = 0;
        bus.pready = bit'($urandom_range(0, 1));
        bus.prdata = $urandom;
      end else if (bus.psel && bus.penable) begin
        chk("access_paddr", bus.paddr, ex_a);
        chk("access_pwdata", bus.pwdata, ex_d);
        chk("access_pwrite", 32'(bus.pwrite), 32'(ex_w));
        bus.pready = (k == nw);
        bus.prdata = (k == nw) ? rdv : $urandom;
        k++;
      end else begin
        chk("idle_penable", 32'(bus.penable), 32'd0);
        chk("idle_paddr", bus.paddr, 32'd0);
        chk("idle_pwdata", bus.pwdata, 32'd0);
        chk("idle_pwrite", 32'(bus.pwrite), 32'd0);
        bus.pready = bit'($urandom_range(0, 1));
        bus.prdata = $urandom;
      end
    end
  end

  // completion monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_ !== 1'b1) continue;
    if (bus.m0_done || bus.m1_done) begin
      if (bus.m0_done && bus.m1_done) begin
        checks++; errors++;
        $display("FAIL done_both: got two done pulses, required one");
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got done m0=%0d m1=%0d, required none",
                 bus.m0_done, bus.m1_done);
      end else begin
        e = sb.pop_front();
        chk("done_id", 32'(bus.m1_done), 32'(e.id));
        chk("done_cycle", 32'(cyc), 32'(e.dc));
        if (!e.w)
          chk("done_rdata", e.id ? bus.m1_rdata : bus.m0_rdata, e.rd);
      end
    end else if (sb.size() > 0 && sb[0].dc <= cyc) begin
      checks++; errors++;
      $display("FAIL done_missing: got no done, required done for m%0d",
               sb[0].id);
      void'(sb.pop_front());
    end
  end

  initial begin
    int n;
    rst_ = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_paddr", bus.paddr, 32'd0);
    chk("rst_m0_done", 32'(bus.m0_done), 32'd0);
    chk("rst_m1_done", 32'(bus.m1_done), 32'd0);
    chk("rst_rdata", bus.m0_rdata, 32'd0);
    @(posedge clk); #3;
    rst_ = 1'b1;
    @(posedge clk); #1;

    fork
      drv(0, 40);
      drv(1, 40);
    join

    n = 0;
    while ((bus.psel || sb.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);

    // reset in the middle of a long ACCESS
    force_wait = 1'b1;
    issue(0, 1'b0, 32'h0000_0010, '0);
    n = 0;
    while (!(bus.psel && bus.penable) && n < 20) begin
      @(posedge clk); #3;
      n++;
    end
    chk("rst_reach_access", 32'(bus.psel && bus.penable), 32'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_ = 1'b0;
    sb.delete();
    pend[0] = 1'b0; pend[1] = 1'b0;
    granted[0] = 1'b0; granted[1] = 1'b0;
    last = 1'b1;
    force_wait = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("midrst_psel", 32'(bus.psel), 32'd0);
    chk("midrst_penable", 32'(bus.penable), 32'd0);
    chk("midrst_paddr", bus.paddr, 32'd0);
    chk("midrst_m0_done", 32'(bus.m0_done), 32'd0);
    issue(1, 1'b0, 32'h0000_0008, '0);
    @(posedge clk); #3;
    rst_ = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.m1_done && n < 60);
    chk("midrst_m1_served", 32'(bus.m1_done), 32'd1);
    set_req(1, 1'b0, 1'b0, '0, '0);
    granted[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
